// File: rtl/lpc_host_if.sv
// Request handshake and LAD/LFRAME# pins of the LPC host, bundled as one port.
// The master modport is the requesting side together with the bus peripheral.
interface lpc_host_if;
  logic        req_i;
  logic        we_i;
  logic [15:0] addr_i;
  logic [7:0]  wdata_i;
  logic [7:0]  rdata_o;
  logic        done_o;
  logic        err_o;
  logic        busy_o;
  logic        lframe_o;
  logic [3:0]  lad_o;
  logic        lad_oe_o;
  logic [3:0]  lad_i;

  modport master (
    output req_i, we_i, addr_i, wdata_i, lad_i,
    input  rdata_o, done_o, err_o, busy_o, lframe_o, lad_o, lad_oe_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, lad_i,
    output rdata_o, done_o, err_o, busy_o, lframe_o, lad_o, lad_oe_o
  );
endinterface

// File: rtl/lpc_host.sv
// LPC host for single-byte TPM-locality read/write cycles, with SYNC wait
// handling, short/long timeout and LFRAME# abort.
module lpc_host #(
  parameter logic [3:0] START_NIBBLE  = 4'b0101,
  parameter int         SHORT_TIMEOUT = 8,
  parameter int         LONG_TIMEOUT  = 1024
) (
  input  logic      clk_i,
  input  logic      rst_i,
  lpc_host_if.slave bus
);

  localparam int CNT_W = $clog2(LONG_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LONG_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_CYCTYPE, S_ADDR, S_WDATA, S_TAR_H,
    S_SYNC, S_RDATA, S_TAR_P, S_ABORT, S_DONE
  } state_t;

  state_t           r_state, w_next;
  logic [1:0]       r_sub;
  logic [CNT_W-1:0] r_cnt;
  logic             r_long, r_we, r_err;
  logic [15:0]      r_addr;
  logic [7:0]       r_wdata, r_rdata;

  logic             w_lframe, w_oe, w_done, w_busy;
  logic [3:0]       w_lad;
  logic             w_sync_ok, w_sync_err, w_sync_long;
  logic [CNT_W-1:0] w_limit;

  assign w_sync_ok   = (bus.lad_i == 4'b0000);
  assign w_sync_err  = (bus.lad_i == 4'b1010);
  assign w_sync_long = (bus.lad_i == 4'b0110);
  // A long-wait nibble in the current cycle already extends the limit.
  assign w_limit = (r_long || w_sync_long) ? CNT_MAX : CNT_W'(SHORT_TIMEOUT);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_lframe = 1'b1;
    w_oe     = 1'b0;
    w_lad    = 4'hF;
    w_done   = 1'b0;
    w_busy   = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.req_i) w_next = S_START;
      end
      S_START: begin
        w_lframe = 1'b0;
        w_oe     = 1'b1;
        w_lad    = START_NIBBLE;
        w_next   = S_CYCTYPE;
      end
      S_CYCTYPE: begin
        w_oe   = 1'b1;
        w_lad  = r_we ? 4'b0010 : 4'b0000;
        w_next = S_ADDR;
      end
      S_ADDR: begin
        w_oe = 1'b1;
        case (r_sub)
          2'd0:    w_lad = r_addr[15:12];
          2'd1:    w_lad = r_addr[11:8];
          2'd2:    w_lad = r_addr[7:4];
          default: w_lad = r_addr[3:0];
        endcase
        if (r_sub == 2'd3) w_next = r_we ? S_WDATA : S_TAR_H;
      end
      S_WDATA: begin
        w_oe  = 1'b1;
        w_lad = r_sub[0] ? r_wdata[7:4] : r_wdata[3:0];
        if (r_sub[0]) w_next = S_TAR_H;
      end
      S_TAR_H: begin
        w_oe = ~r_sub[0];
        if (r_sub[0]) w_next = S_SYNC;
      end
      S_SYNC: begin
        if (w_sync_ok || w_sync_err) w_next = r_we ? S_TAR_P : S_RDATA;
        else if (r_cnt >= w_limit)   w_next = S_ABORT;
      end
      S_RDATA: if (r_sub[0]) w_next = S_TAR_P;
      S_TAR_P: if (r_sub[0]) w_next = S_DONE;
      S_ABORT: begin
        w_lframe = 1'b0;
        w_oe     = 1'b1;
        if (r_sub == 2'd3) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_busy = 1'b0;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sub   <= '0;
      r_cnt   <= '0;
      r_long  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_sub <= (w_next == r_state) ? r_sub + 2'd1 : 2'd0;
      if (r_state == S_IDLE && bus.req_i) begin
        r_we    <= bus.we_i;
        r_addr  <= bus.addr_i;
        r_wdata <= bus.wdata_i;
        r_err   <= 1'b0;
        r_long  <= 1'b0;
      end
      if (r_state == S_SYNC) begin
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
        if (w_sync_long) r_long <= 1'b1;
        if (w_sync_err || w_next == S_ABORT) r_err <= 1'b1;
      end else if (w_next == S_SYNC) begin
        r_cnt <= CNT_W'(1);
      end else if (r_state == S_IDLE) begin
        r_cnt <= '0;
      end
      if (r_state == S_RDATA) begin
        if (r_sub[0]) r_rdata[7:4] <= bus.lad_i;
        else          r_rdata[3:0] <= bus.lad_i;
      end
    end
  end

  assign bus.lframe_o = w_lframe;
  assign bus.lad_oe_o = w_oe;
  assign bus.lad_o    = w_lad;
  assign bus.done_o   = w_done;
  assign bus.busy_o   = w_busy;
  assign bus.err_o    = r_err;
  assign bus.rdata_o  = r_rdata;

endmodule

// File: tb/tb_lpc_host.sv
// Bench for lpc_host: a transaction-level model expands each request into its
// expected per-cycle bus trace, and one negedge process compares against it.
module tb_lpc_host;
  localparam int SHORT_TO = 8;
  localparam int LONG_TO  = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lpc_host_if bus_if();

  lpc_host #(
    .START_NIBBLE (4'b0101),
    .SHORT_TIMEOUT(SHORT_TO),
    .LONG_TIMEOUT (LONG_TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus_if)
  );

  typedef struct {
    logic       lframe;
    logic       oe;
    logic [3:0] lad;
    logic [3:0] lad_in;
    logic       done;
    logic       busy;
    logic       err;
    logic [7:0] rdata;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  int         checks = 0;
  int         errors = 0;
  bit         chk_en = 1'b0;
  logic       m_err = 1'b0;
  logic [7:0] m_rdata = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic lf, input logic oe, input logic [3:0] lad,
                      input logic [3:0] lin, input logic dn, input logic bsy);
    exp_t e;
    e.lframe = lf; e.oe = oe; e.lad = lad; e.lad_in = lin;
    e.done = dn; e.busy = bsy; e.err = m_err; e.rdata = m_rdata;
    exp_q.push_back(e);
  endtask

  // Expected trace from the acceptance cycle (IDLE) through DONE.
  task automatic build(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                       input logic [3:0] sq[$], input logic [7:0] rd);
    int n; logic lng, fin, to_hit; logic [3:0] nib;
    push(1, 0, 4'hF, 4'hF, 0, 0);
    m_err = 1'b0;
    push(0, 1, 4'b0101, 4'hF, 0, 1);
    push(1, 1, we ? 4'b0010 : 4'b0000, 4'hF, 0, 1);
    for (int i = 0; i < 4; i++) push(1, 1, addr[15-4*i -: 4], 4'hF, 0, 1);
    if (we) begin
      push(1, 1, wd[3:0], 4'hF, 0, 1);
      push(1, 1, wd[7:4], 4'hF, 0, 1);
    end
    push(1, 1, 4'hF, 4'hF, 0, 1);
    push(1, 0, 4'hF, 4'hF, 0, 1);
    n = 0; lng = 0; fin = 0; to_hit = 0;
    while (!fin) begin
      nib = (n < sq.size()) ? sq[n] : 4'hF;
      n++;
      push(1, 0, 4'hF, nib, 0, 1);
      if (nib == 4'h0) fin = 1;
      else if (nib == 4'hA) begin fin = 1; m_err = 1'b1; end
      else begin
        if (nib == 4'h6) lng = 1;
        if (n >= (lng ? LONG_TO : SHORT_TO)) begin fin = 1; to_hit = 1; end
      end
    end
    if (to_hit) begin
      m_err = 1'b1;
      repeat (4) push(0, 1, 4'hF, 4'hF, 0, 1);
    end else begin
      if (!we) begin
        push(1, 0, 4'hF, rd[3:0], 0, 1);
        m_rdata[3:0] = rd[3:0];
        push(1, 0, 4'hF, rd[7:4], 0, 1);
        m_rdata[7:4] = rd[7:4];
      end
      push(1, 0, 4'hF, 4'hF, 0, 1);
      push(1, 0, 4'hF, 4'hF, 0, 1);
    end
    push(1, 0, 4'hF, 4'hF, 1, 0);
  endtask

  // Called at posedge+1 of an IDLE cycle; returns in the DONE cycle.
  task automatic go(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                    output int lat);
    int lat_exp;
    lat_exp = exp_q.size() - 2;
    bus_if.req_i = 1'b1; bus_if.we_i = we; bus_if.addr_i = addr; bus_if.wdata_i = wd;
    lat = 0;
    forever begin
      @(posedge clk); #1;
      bus_if.req_i   = 1'($urandom_range(0, 1));
      bus_if.we_i    = 1'($urandom_range(0, 1));
      bus_if.addr_i  = 16'($urandom);
      bus_if.wdata_i = 8'($urandom);
      if (bus_if.done_o === 1'b1) break;
      lat++;
      if (lat > 3000) begin
        chk("done_timeout", 32'(lat), 32'(lat_exp));
        break;
      end
    end
    chk("latency", 32'(lat), 32'(lat_exp));
  endtask

  task automatic finish_txn();
    @(posedge clk); #1;
    bus_if.req_i = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},   bus_if.busy_o,   0);
    chk({tag, "_lframe"}, bus_if.lframe_o, 1);
    chk({tag, "_oe"},     bus_if.lad_oe_o, 0);
    chk({tag, "_lad"},    bus_if.lad_o,    4'hF);
    chk({tag, "_done"},   bus_if.done_o,   0);
    chk({tag, "_err"},    bus_if.err_o,    0);
    chk({tag, "_rdata"},  bus_if.rdata_o,  8'h00);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      bus_if.lad_i = 4'hF;
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      bus_if.lad_i = cur.lad_in;
      chk("lframe", bus_if.lframe_o, cur.lframe);
      chk("lad_oe", bus_if.lad_oe_o, cur.oe);
      if (cur.oe) chk("lad", bus_if.lad_o, cur.lad);
      chk("done",  bus_if.done_o,  cur.done);
      chk("busy",  bus_if.busy_o,  cur.busy);
      chk("err",   bus_if.err_o,   cur.err);
      chk("rdata", bus_if.rdata_o, cur.rdata);
    end else if (chk_en) begin
      bus_if.lad_i = 4'hF;
      chk("idle_lframe", bus_if.lframe_o, 1);
      chk("idle_oe",     bus_if.lad_oe_o, 0);
      chk("idle_busy",   bus_if.busy_o,   0);
      chk("idle_done",   bus_if.done_o,   0);
      chk("idle_err",    bus_if.err_o,    m_err);
      chk("idle_rdata",  bus_if.rdata_o,  m_rdata);
    end
  end

  initial begin
    logic [3:0] sq[$];
    logic [3:0] lit43[9];
    logic [3:0] pool[7];
    logic [3:0] pool_nl[6];
    int lat, mode, w;
    logic we; logic [15:0] a; logic [7:0] wd, rd;

    lit43   = '{4'h5, 4'h2, 4'h0, 4'hF, 4'h0, 4'h0, 4'h5, 4'hA, 4'hF};
    pool    = '{4'h5, 4'hF, 4'h6, 4'h3, 4'h9, 4'hC, 4'h1};
    pool_nl = '{4'h5, 4'hF, 4'h3, 4'h9, 4'hC, 4'h1};
    bus_if.req_i = 1'b0; bus_if.we_i = 1'b0; bus_if.addr_i = '0; bus_if.wdata_i = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    chk_reset_vals("rst0");
    @(posedge clk); #1;

    // Write 0F00/A5, immediate ready.
    sq = '{4'h0};
    build(1, 16'h0F00, 8'hA5, sq, 8'h00);
    chk("m43_len", 32'(exp_q.size()), 15);
    for (int i = 0; i < 9; i++) chk("m43_lad", exp_q[i+1].lad, lit43[i]);
    chk("m43_z", exp_q[10].oe, 0);
    go(1, 16'h0F00, 8'hA5, lat);
    chk("w43_lat", 32'(lat), 13);
    chk("w43_err", bus_if.err_o, 0);
    finish_txn();

    // Read 0F18 with two wait nibbles, data C4.
    sq = '{4'h5, 4'h5, 4'h0};
    build(0, 16'h0F18, 8'h00, sq, 8'hC4);
    chk("m44_len", 32'(exp_q.size()), 17);
    go(0, 16'h0F18, 8'h00, lat);
    chk("r44_lat", 32'(lat), 15);
    finish_txn();
    chk("r44_rdata", bus_if.rdata_o, 8'hC4);

    // Read with no ready: short timeout then abort.
    sq = {};
    for (int i = 0; i < 12; i++) sq.push_back(4'hF);
    build(0, 16'h1234, 8'h00, sq, 8'h00);
    chk("m45_len", 32'(exp_q.size()), 22);
    go(0, 16'h1234, 8'h00, lat);
    chk("r45_lat", 32'(lat), 20);
    chk("r45_err", bus_if.err_o, 1);
    finish_txn();

    // Write with 100 long-wait nibbles, then ready.
    sq = {};
    for (int i = 0; i < 100; i++) sq.push_back(4'h6);
    sq.push_back(4'h0);
    build(1, 16'h00C3, 8'h3C, sq, 8'h00);
    go(1, 16'h00C3, 8'h3C, lat);
    chk("w46_lat", 32'(lat), 113);
    chk("w46_err", bus_if.err_o, 0);
    finish_txn();

    // Read with error SYNC, data FF.
    sq = '{4'hA};
    build(0, 16'h5A5A, 8'h00, sq, 8'hFF);
    go(0, 16'h5A5A, 8'h00, lat);
    chk("r47_lat", 32'(lat), 13);
    chk("r47_err", bus_if.err_o, 1);
    finish_txn();
    chk("r47_rdata", bus_if.rdata_o, 8'hFF);

    // One long-wait nibble, then never ready: long timeout.
    sq = '{4'h6};
    build(0, 16'hBEEF, 8'h00, sq, 8'h00);
    go(0, 16'hBEEF, 8'h00, lat);
    chk("rlong_lat", 32'(lat), 1036);
    chk("rlong_err", bus_if.err_o, 1);
    finish_txn();

    // Reset in the middle of ADDR.
    sq = '{4'h0};
    build(0, 16'h4321, 8'h00, sq, 8'h00);
    bus_if.req_i = 1'b1; bus_if.we_i = 1'b0; bus_if.addr_i = 16'h4321;
    repeat (4) begin @(posedge clk); #1; bus_if.req_i = 1'b0; end
    chk("r48_inaddr", bus_if.busy_o, 1);
    rst = 1'b1;
    exp_q.delete();
    m_err = 1'b0; m_rdata = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_vals("rst48");
    @(posedge clk); #1;

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      we = 1'($urandom_range(0, 1));
      a  = 16'($urandom);
      wd = 8'($urandom);
      rd = 8'($urandom);
      mode = $urandom_range(0, 3);
      sq = {};
      if (mode < 3) begin
        w = $urandom_range(0, 6);
        for (int i = 0; i < w; i++) sq.push_back(pool[$urandom_range(0, 6)]);
        sq.push_back(($urandom_range(0, 3) == 0) ? 4'hA : 4'h0);
      end else begin
        for (int i = 0; i < 10; i++) sq.push_back(pool_nl[$urandom_range(0, 5)]);
      end
      build(we, a, wd, sq, rd);
      go(we, a, wd, lat);
      finish_txn();
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
